distance_filter: RTL and testbench

DISTANCE_FILTER -- requirements
Module: distance_filter

---
 rtl/distance_filter_pkg.sv | 36 +++
 rtl/distance_filter_divider.sv | 53 +++++
 rtl/distance_filter.sv | 127 ++++++++++++
 tb/tb_distance_filter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/distance_filter_pkg.sv
// Shared types, default constants and the median-of-3 helper for the distance filter.
package distance_filter_pkg;

    localparam int unsigned CYC_PER_CM  = 2900;
    localparam int unsigned NEAR_CM     = 20;
    localparam int unsigned HYST_CM     = 3;
    localparam int unsigned TIMEOUT_CYC = 9001500;

    localparam int unsigned CNT_W = 20;
    localparam int unsigned DIV_W = 12;
    localparam int unsigned CM_W  = 8;

    typedef enum logic [1:0] {
        StIdle,
        StDiv,
        StMedian,
        StOut
    } state_e;

    function automatic logic [CM_W-1:0] median3(input logic [CM_W-1:0] a,
                                                input logic [CM_W-1:0] b,
                                                input logic [CM_W-1:0] c);
        logic [CM_W-1:0] lo;
        logic [CM_W-1:0] hi;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        if (c < lo) begin
            return lo;
        end else if (c > hi) begin
            return hi;
        end else begin
            return c;
        end
    endfunction

endpackage

// File: rtl/distance_filter_divider.sv
// Restoring divider, one quotient bit per cycle. done is high in the cycle that
// performs the final iteration, so quotient is complete from the following cycle.
module seq_divider #(
    parameter int unsigned N_W = 20,
    parameter int unsigned D_W = 12
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic [N_W-1:0] quotient,
    output logic           done
);
    localparam int unsigned CW = $clog2(N_W);

    // quo_q shifts dividend bits out of the top while quotient bits enter at the bottom
    logic [N_W-1:0] quo_q;
    logic [D_W-1:0] rem_q;
    logic [CW-1:0]  cnt_q;
    logic           busy_q;
    logic [D_W:0]   rem_shift;
    logic           fits;
    logic [D_W-1:0] rem_next;

    assign rem_shift = {rem_q, quo_q[N_W-1]};
    assign fits      = rem_shift >= {1'b0, divisor};
    assign rem_next  = fits ? D_W'(rem_shift - {1'b0, divisor}) : rem_shift[D_W-1:0];
    assign quotient  = quo_q;
    assign done      = busy_q && (cnt_q == CW'(N_W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            quo_q  <= dividend;
            rem_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            quo_q <= {quo_q[N_W-2:0], fits};
            rem_q <= rem_next;
            cnt_q <= cnt_q + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/distance_filter.sv
// Converts ultrasonic echo counts to cm, median-filters them, and flags near
// obstacles with hysteresis plus a stale-data timeout.
module distance_filter #(
    parameter int unsigned CYC_PER_CM  = distance_filter_pkg::CYC_PER_CM,
    parameter int unsigned NEAR_CM     = distance_filter_pkg::NEAR_CM,
    parameter int unsigned HYST_CM     = distance_filter_pkg::HYST_CM,
    parameter int unsigned TIMEOUT_CYC = distance_filter_pkg::TIMEOUT_CYC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] i_distance,
    input  logic        i_m_end,
    output logic [7:0]  o_dist_cm,
    output logic        o_dist_valid,
    output logic        o_obstacle,
    output logic        o_stale,
    output logic        o_busy
);
    import distance_filter_pkg::*;

    localparam int unsigned TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMAX   = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMAX_1 = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0] NEAR_TH   = 8'(NEAR_CM);
    localparam logic [7:0] CLEAR_TH  = 8'(NEAR_CM + HYST_CM);
    localparam logic [DIV_W-1:0] DIVISOR = DIV_W'(CYC_PER_CM);

    state_e          state_q;
    logic            i_m_end_d;
    logic            edge_det;
    logic            accept;
    logic            div_done;
    logic [CNT_W-1:0] quo;
    logic [7:0]      q_sat;
    logic [7:0]      result;
    // Two previous samples; with the incoming quotient they form the 3-entry window
    logic [7:0]      win0_q;
    logic [7:0]      win1_q;
    logic [1:0]      win_cnt_q;
    logic [TW-1:0]   to_cnt_q;
    logic            stale_set;

    assign edge_det  = i_m_end & ~i_m_end_d;
    assign accept    = edge_det && (state_q == StIdle);
    assign q_sat     = (quo > CNT_W'(255)) ? 8'd255 : quo[7:0];
    assign result    = (win_cnt_q < 2'd2) ? q_sat : median3(q_sat, win0_q, win1_q);
    // An accepted edge in the saturating cycle keeps stale low
    assign stale_set = !accept && (to_cnt_q == TMAX_1);

    seq_divider #(
        .N_W(CNT_W),
        .D_W(DIV_W)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .start   (accept),
        .dividend(i_distance),
        .divisor (DIVISOR),
        .quotient(quo),
        .done    (div_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            i_m_end_d    <= 1'b0;
            o_dist_cm    <= '0;
            o_dist_valid <= 1'b0;
            o_obstacle   <= 1'b0;
            o_stale      <= 1'b0;
            o_busy       <= 1'b0;
            win0_q       <= '0;
            win1_q       <= '0;
            win_cnt_q    <= '0;
            to_cnt_q     <= '0;
        end else begin
            i_m_end_d    <= i_m_end;
            o_dist_valid <= 1'b0;

            if (accept) begin
                to_cnt_q <= '0;
            end else if (to_cnt_q != TMAX) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end

            if (stale_set) begin
                o_stale    <= 1'b1;
                o_obstacle <= 1'b1;
                win_cnt_q  <= '0;
            end

            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q <= StDiv;
                        o_busy  <= 1'b1;
                    end
                end
                StDiv: begin
                    if (div_done) begin
                        state_q <= StMedian;
                    end
                end
                StMedian: begin
                    win0_q       <= q_sat;
                    win1_q       <= win0_q;
                    win_cnt_q    <= (win_cnt_q == 2'd3) ? 2'd3 : win_cnt_q + 2'd1;
                    o_dist_cm    <= result;
                    o_dist_valid <= 1'b1;
                    o_stale      <= 1'b0;
                    if (result < NEAR_TH) begin
                        o_obstacle <= 1'b1;
                    end else if (result >= CLEAR_TH) begin
                        o_obstacle <= 1'b0;
                    end
                    state_q <= StOut;
                end
                StOut: begin
                    state_q <= StIdle;
                    o_busy  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_distance_filter.sv
// Directed bench for distance_filter: vector table plus hand sequences for
// reset-time capture, ignored edges, mid-capture reset and the stale timeout.
module tb_distance_filter;

    localparam int unsigned TO = 300;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] i_distance;
    logic        i_m_end;
    logic [7:0]  o_dist_cm;
    logic        o_dist_valid;
    logic        o_obstacle;
    logic        o_stale;
    logic        o_busy;

    int checks   = 0;
    int failures = 0;

    distance_filter #(
        .CYC_PER_CM (2900),
        .NEAR_CM    (20),
        .HYST_CM    (3),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_distance  (i_distance),
        .i_m_end     (i_m_end),
        .o_dist_cm   (o_dist_cm),
        .o_dist_valid(o_dist_valid),
        .o_obstacle  (o_obstacle),
        .o_stale     (o_stale),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_before;
        logic [19:0] cnt;
        logic [7:0]  exp_cm;
        logic        exp_obst;
    } vec_t;

    vec_t vecs[26];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst     = 1'b1;
        i_m_end = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Raise i_m_end in cycle T and watch cycles T..T+39 for the result strobe
    task automatic measure(input logic [19:0] cnt, output logic [7:0] cm, output logic obst,
                           output int first, output int npulse, output logic [3:0] busy_pat);
        cm       = '0;
        obst     = 1'b0;
        first    = -1;
        npulse   = 0;
        busy_pat = '0;
        @(posedge clk);
        #1;
        i_distance = cnt;
        i_m_end    = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0)  busy_pat[3] = o_busy;
            if (k == 1)  busy_pat[2] = o_busy;
            if (k == 22) busy_pat[1] = o_busy;
            if (k == 23) busy_pat[0] = o_busy;
            if (o_dist_valid) begin
                npulse++;
                if (first < 0) begin
                    first = k;
                    cm    = o_dist_cm;
                    obst  = o_obstacle;
                end
            end
        end
        @(posedge clk);
        #1;
        i_m_end = 1'b0;
    endtask

    initial begin
        logic [7:0] cm;
        logic       obst;
        int         first;
        int         npulse;
        int         second;
        logic [3:0] busy_pat;

        rst        = 1'b1;
        i_m_end    = 1'b0;
        i_distance = '0;

        vecs[0]  = '{1'b1, 20'd58000,   8'd20,  1'b0};
        vecs[1]  = '{1'b1, 20'd60899,   8'd20,  1'b0};
        vecs[2]  = '{1'b1, 20'd14500,   8'd5,   1'b1};
        vecs[3]  = '{1'b1, 20'd0,       8'd0,   1'b1};
        vecs[4]  = '{1'b1, 20'd2899,    8'd0,   1'b1};
        vecs[5]  = '{1'b1, 20'd739499,  8'd254, 1'b0};
        vecs[6]  = '{1'b1, 20'd742400,  8'd255, 1'b0};
        vecs[7]  = '{1'b1, 20'd1048575, 8'd255, 1'b0};
        vecs[8]  = '{1'b1, 20'd87000,   8'd30,  1'b0};
        vecs[9]  = '{1'b0, 20'd290000,  8'd100, 1'b0};
        vecs[10] = '{1'b0, 20'd116000,  8'd40,  1'b0};
        vecs[11] = '{1'b0, 20'd101500,  8'd40,  1'b0};
        vecs[12] = '{1'b1, 20'd72500,   8'd25,  1'b0};
        vecs[13] = '{1'b0, 20'd74000,   8'd25,  1'b0};
        vecs[14] = '{1'b0, 20'd72500,   8'd25,  1'b0};
        vecs[15] = '{1'b0, 20'd55100,   8'd25,  1'b0};
        vecs[16] = '{1'b0, 20'd57100,   8'd19,  1'b1};
        vecs[17] = '{1'b0, 20'd55100,   8'd19,  1'b1};
        vecs[18] = '{1'b0, 20'd60900,   8'd19,  1'b1};
        vecs[19] = '{1'b0, 20'd63000,   8'd21,  1'b1};
        vecs[20] = '{1'b0, 20'd60900,   8'd21,  1'b1};
        vecs[21] = '{1'b0, 20'd66700,   8'd21,  1'b1};
        vecs[22] = '{1'b0, 20'd66700,   8'd23,  1'b0};
        vecs[23] = '{1'b0, 20'd69599,   8'd23,  1'b0};
        vecs[24] = '{1'b1, 20'd1,       8'd0,   1'b1};
        vecs[25] = '{1'b0, 20'd5800,    8'd2,   1'b1};

        do_reset();
        @(negedge clk);
        check("reset_dist_cm", 32'(o_dist_cm), 0);
        check("reset_valid", 32'(o_dist_valid), 0);
        check("reset_obstacle", 32'(o_obstacle), 0);
        check("reset_stale", 32'(o_stale), 0);
        check("reset_busy", 32'(o_busy), 0);

        foreach (vecs[i]) begin
            if (vecs[i].rst_before) do_reset();
            measure(vecs[i].cnt, cm, obst, first, npulse, busy_pat);
            check($sformatf("vec%0d_cm", i), 32'(cm), 32'(vecs[i].exp_cm));
            check($sformatf("vec%0d_obst", i), 32'(obst), 32'(vecs[i].exp_obst));
            check($sformatf("vec%0d_latency", i), first, 22);
            check($sformatf("vec%0d_pulses", i), npulse, 1);
            check($sformatf("vec%0d_busy", i), 32'(busy_pat), 32'(4'b0110));
        end

        // i_m_end already high as reset releases: capture starts in the first cycle
        @(posedge clk);
        #1;
        rst        = 1'b1;
        i_distance = 20'd14500;
        i_m_end    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst   = 1'b0;
        first = -1;
        cm    = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (o_dist_valid && first < 0) begin
                first = k;
                cm    = o_dist_cm;
            end
        end
        check("rstrel_latency", first, 22);
        check("rstrel_cm", 32'(cm), 5);
        @(posedge clk);
        #1;
        i_m_end = 1'b0;

        // Second edge at T+10 while dividing is ignored
        first  = -1;
        npulse = 0;
        cm     = '0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                i_distance = 20'd58000;
                i_m_end    = 1'b1;
            end
            if (k == 5) i_m_end = 1'b0;
            if (k == 10) begin
                i_distance = 20'd290000;
                i_m_end    = 1'b1;
            end
            @(negedge clk);
            if (o_dist_valid) begin
                npulse++;
                if (first < 0) begin
                    first = k;
                    cm    = o_dist_cm;
                end
            end
        end
        check("ignore_pulses", npulse, 1);
        check("ignore_latency", first, 22);
        check("ignore_cm", 32'(cm), 20);
        check("ignore_obst_held", 32'(o_obstacle), 1);
        @(posedge clk);
        #1;
        i_m_end = 1'b0;

        // Reset at T+5 aborts the capture
        npulse = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                i_distance = 20'd14500;
                i_m_end    = 1'b1;
            end
            if (k == 5) begin
                rst     = 1'b1;
                i_m_end = 1'b0;
            end
            if (k == 6) rst = 1'b0;
            @(negedge clk);
            if (o_dist_valid) npulse++;
        end
        check("abort_pulses", npulse, 0);
        check("abort_dist_cm", 32'(o_dist_cm), 0);
        check("abort_obstacle", 32'(o_obstacle), 0);
        check("abort_stale", 32'(o_stale), 0);
        check("abort_busy", 32'(o_busy), 0);

        // Fill the window with 100 cm, then let it time out
        for (int r = 0; r < 3; r++) begin
            measure(20'd290000, cm, obst, first, npulse, busy_pat);
        end
        check("pre_stale_cm", 32'(cm), 100);
        check("pre_stale_flag", 32'(o_stale), 0);
        first = -1;
        for (int k = 0; k < 2 * TO; k++) begin
            @(negedge clk);
            if (o_stale && first < 0) first = k;
        end
        check("stale_reached", 32'(first >= 0), 1);
        check("stale_flag", 32'(o_stale), 1);
        check("stale_obstacle", 32'(o_obstacle), 1);
        measure(20'd145000, cm, obst, first, npulse, busy_pat);
        check("after_stale_cm", 32'(cm), 50);
        check("after_stale_obst", 32'(obst), 0);
        check("after_stale_latency", first, 22);
        check("after_stale_flag", 32'(o_stale), 0);

        // Edge exactly where the counter would saturate, then a real timeout
        npulse = 0;
        second = -1;
        for (int k = 0; k < 2 * TO + 5; k++) begin
            @(posedge clk);
            #1;
            if (k == 0 || k == TO) begin
                i_distance = 20'd145000;
                i_m_end    = 1'b1;
            end
            if (k == 40 || k == TO + 40) i_m_end = 1'b0;
            @(negedge clk);
            if (o_dist_valid) begin
                npulse++;
                if (k > 22) second = k;
            end
            if (k == TO)         check("edge_win_stale_t", 32'(o_stale), 0);
            if (k == TO + 1)     check("edge_win_stale_t1", 32'(o_stale), 0);
            if (k == 2 * TO)     check("timeout_not_early", 32'(o_stale), 0);
            if (k == 2 * TO + 1) check("timeout_exact", 32'(o_stale), 1);
            if (k == 2 * TO + 1) check("timeout_obstacle", 32'(o_obstacle), 1);
        end
        check("edge_win_pulses", npulse, 2);
        check("edge_win_latency", second, TO + 22);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
